// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
//   Shares one 32K x 8 single-port on-chip RAM (1-cycle read latency) between
//   the CPU data port (m0) and the sample-capture write engine (m1).
//   At most one access is issued per clock. Read data goes back to the port
//   that issued the read, qualified by that port's readdatavalid one cycle
//   after acceptance.
//
//   Build option: define ONCHIP_ARB_ROUND_ROBIN_EN for strict alternation when
//   both ports request. The default build uses fixed priority for m0 with a
//   HOLD_MAX anti-starvation slot for m1.
//
//   Handshake (both master ports): a request (read or write high) must stay
//   stable until the cycle in which waitrequest is low; the access is taken
//   on the rising edge that closes that cycle. read and write both high is a
//   write. Reads answer with readdatavalid high for exactly the next cycle.
//
//   Debug: dbg_last_gnt is the arbitration state (1 = m1 granted last),
//   dbg_run_cnt is the count of consecutive m0 grants while m1 was waiting.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              dbg_last_gnt,
  output logic [3:0]        dbg_run_cnt
);

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_run_cnt;
  logic [3:0]        w_run_cnt_nxt;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_rdv0;
  logic              r_rdv1;

  logic              w_req0;
  logic              w_req1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rd_acc0;
  logic              w_rd_acc1;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Grant decision: a lone requester wins at once; contention is settled by
  // the configured policy. Nothing is granted while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (w_req0 && !w_req1) begin
        w_gnt0 = 1'b1;
      end else if (w_req1 && !w_req0) begin
        w_gnt1 = 1'b1;
      end else if (w_req0 && w_req1) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
        if (r_state == LAST0) w_gnt1 = 1'b1;
        else                  w_gnt0 = 1'b1;
`else
        if (r_run_cnt == HOLD_LIM) w_gnt1 = 1'b1;
        else                       w_gnt0 = 1'b1;
`endif
      end
    end
  end

  // Next arbitration state: remember who won; track m0's run while m1 waits.
  always_comb begin
    w_state_nxt   = r_state;
    w_run_cnt_nxt = r_run_cnt;
    if (w_gnt1)      w_state_nxt = LAST1;
    else if (w_gnt0) w_state_nxt = LAST0;
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    w_run_cnt_nxt = '0;
`else
    if (w_gnt1 || !w_req1) begin
      w_run_cnt_nxt = '0;
    end else if (w_gnt0 && (r_run_cnt != HOLD_LIM)) begin
      w_run_cnt_nxt = r_run_cnt + 4'd1;
    end
`endif
  end

  // Arbitration state register; reset favours m0 for the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= LAST1;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_cnt_nxt;
    end
  end

  // Keep the last issued address so the RAM address is steady when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_addr <= '0;
    end else if (w_gnt0) begin
      r_last_addr <= m0_address;
    end else if (w_gnt1) begin
      r_last_addr <= m1_address;
    end
  end

  assign w_rd_acc0 = w_gnt0 & m0_read & ~m0_write;
  assign w_rd_acc1 = w_gnt1 & m1_read & ~m1_write;

  // Read-return tags: one cycle after an accepted read; reset drops them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdv0 <= 1'b0;
      r_rdv1 <= 1'b0;
    end else begin
      r_rdv0 <= w_rd_acc0;
      r_rdv1 <= w_rd_acc1;
    end
  end

  // RAM-side mux: the granted port drives the RAM in the same cycle.
  always_comb begin
    mem_address    = r_last_addr;
    mem_write      = 1'b0;
    mem_writedata  = m0_writedata;
    mem_chipselect = w_gnt0 | w_gnt1;
    if (w_gnt0) begin
      mem_address   = m0_address;
      mem_write     = m0_write;
      mem_writedata = m0_writedata;
    end else if (w_gnt1) begin
      mem_address   = m1_address;
      mem_write     = m1_write;
      mem_writedata = m1_writedata;
    end
  end

  assign mem_clken        = 1'b1;
  assign m0_waitrequest   = reset | (w_req0 & ~w_gnt0);
  assign m1_waitrequest   = reset | (w_req1 & ~w_gnt1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_rdv0;
  assign m1_readdatavalid = r_rdv1;
  assign dbg_last_gnt     = (r_state == LAST1);
  assign dbg_run_cnt      = r_run_cnt;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration rules and a
// shadow copy of RAM contents.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;
  localparam int HOLD_MAX = 4;
  localparam int W        = DATA_W + 1;   // {port, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              dbg_last_gnt;
  logic [3:0]        dbg_run_cnt;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .dbg_last_gnt(dbg_last_gnt), .dbg_run_cnt(dbg_run_cnt)
  );

  // RAM slave: registered read, write at the clock edge.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      else           mem_readdata     <= ram[mem_address];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  int n_cmp = 0;
  int n_bad = 0;
  int n_rdv0 = 0;
  int n_rdv1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Decides, for each cycle, who the arbitration rules say should win, what
  // the RAM should see, and what read data each port is owed.
  bit                m_last;       // 1: m1 was the most recent winner
  int                m_streak;     // m0 wins in a row while m1 kept asking
  logic [ADDR_W-1:0] m_last_addr;
  bit                m_pend0, m_pend1;

  initial begin : ref_model
    bit r0, r1, g0, g1, we;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] wd;
    forever begin
      @(negedge clk);
      check("clken", 32'(mem_clken), 32'd1);
      if (reset) begin
        check("rst_wait0", 32'(m0_waitrequest), 32'd1);
        check("rst_wait1", 32'(m1_waitrequest), 32'd1);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_we", 32'(mem_write), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
        check("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
        check("rst_last", 32'(dbg_last_gnt), 32'd1);
        check("rst_run", 32'(dbg_run_cnt), 32'd0);
        m_last = 1'b1; m_streak = 0; m_last_addr = '0;
        m_pend0 = 1'b0; m_pend1 = 1'b0;
        exp_q.delete();
      end else begin
        check("rdv0_timing", 32'(m0_readdatavalid), 32'(m_pend0));
        check("rdv1_timing", 32'(m1_readdatavalid), 32'(m_pend1));
        check("dbg_last", 32'(dbg_last_gnt), 32'(m_last));
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
        check("dbg_run", 32'(dbg_run_cnt), 32'd0);
`else
        check("dbg_run", 32'(dbg_run_cnt), 32'(m_streak));
`endif
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        g0 = 1'b0; g1 = 1'b0;
        if (r0 && r1) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
          if (m_last) g0 = 1'b1; else g1 = 1'b1;
`else
          if (m_streak >= HOLD_MAX) g1 = 1'b1; else g0 = 1'b1;
`endif
        end else if (r0) begin
          g0 = 1'b1;
        end else if (r1) begin
          g1 = 1'b1;
        end
        if (r0) check("wait0", 32'(m0_waitrequest), 32'(!g0));
        if (r1) check("wait1", 32'(m1_waitrequest), 32'(!g1));
        ea = m_last_addr; we = 1'b0; wd = '0;
        if (g0) begin ea = m0_address; we = m0_write; wd = m0_writedata; end
        if (g1) begin ea = m1_address; we = m1_write; wd = m1_writedata; end
        check("mem_cs", 32'(mem_chipselect), 32'(g0 | g1));
        check("mem_addr", 32'(mem_address), 32'(ea));
        check("mem_we", 32'(mem_write), 32'(we));
        if (we) check("mem_wdata", 32'(mem_writedata), 32'(wd));
        // Outcome of the coming edge.
        m_pend0 = g0 && !we;
        m_pend1 = g1 && !we;
        if (g0 || g1) m_last_addr = ea;
        if (we)      shadow[ea] = wd;
        else if (g0) exp_q.push_back({1'b0, shadow[ea]});
        else if (g1) exp_q.push_back({1'b1, shadow[ea]});
        if (g1)      m_last = 1'b1;
        else if (g0) m_last = 1'b0;
        if (g1 || !r1)     m_streak = 0;
        else if (g0 && r1) m_streak = m_streak + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] item;
    bit port;
    forever begin
      @(negedge clk);
      if (m0_readdatavalid || m1_readdatavalid) begin
        check("valid_exclusive", 32'(m0_readdatavalid & m1_readdatavalid), 32'd0);
        if (m0_readdatavalid) n_rdv0++;
        if (m1_readdatavalid) n_rdv1++;
        port = m1_readdatavalid;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_readdatavalid");
        end else begin
          item = exp_q.pop_front();
          check("rd_port", 32'(port), 32'(item[DATA_W]));
          check("rd_data", 32'(port ? m1_readdata : m0_readdata), 32'(item[DATA_W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end one time unit after a rising edge.
  task automatic apply_reset();
    reset = 1'b1;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drive_pair(input bit v0, input bit w0, input logic [ADDR_W-1:0] a0,
                            input logic [DATA_W-1:0] d0,
                            input bit v1, input bit w1, input logic [ADDR_W-1:0] a1,
                            input logic [DATA_W-1:0] d1);
    bit p0, p1, c0, c1;
    int guard;
    m0_read = v0 & !w0; m0_write = v0 & w0; m0_address = a0; m0_writedata = d0;
    m1_read = v1 & !w1; m1_write = v1 & w1; m1_address = a1; m1_writedata = d1;
    p0 = v0; p1 = v1; guard = 0;
    while ((p0 || p1) && guard < 32) begin
      @(negedge clk);
      c0 = p0 && !m0_waitrequest;
      c1 = p1 && !m1_waitrequest;
      @(posedge clk); #1;
      if (c0) begin m0_read = 1'b0; m0_write = 1'b0; p0 = 1'b0; end
      if (c1) begin m1_read = 1'b0; m1_write = 1'b0; p1 = 1'b0; end
      guard++;
    end
    if (p0 || p1) begin
      fail_now("accept_timeout");
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    end
  endtask

  task automatic rand_req(output logic rd, output logic wr,
                          output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    rd = 1'b0; wr = 1'b0;
    a = ($urandom_range(0, 15) == 0) ? 15'h7FFF : ADDR_W'($urandom_range(0, 31));
    d = DATA_W'($urandom);
    if ($urandom_range(0, 9) < 7) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? ($urandom_range(0, 7) == 0) : 1'b1;
    end
  endtask

  task automatic run_random(input int n);
    bit a0, a1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      a0 = (m0_read || m0_write) && !m0_waitrequest;
      a1 = (m1_read || m1_write) && !m1_waitrequest;
      @(posedge clk); #1;
      if (a0 || !(m0_read || m0_write)) rand_req(m0_read, m0_write, m0_address, m0_writedata);
      if (a1 || !(m1_read || m1_write)) rand_req(m1_read, m1_write, m1_address, m1_writedata);
    end
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bit pat [10];
    int base0, base1;
    reset = 1'b0;
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
    mem_readdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset arriving right after an m0 read was accepted drops the response.
    m0_address = 15'h0005; m0_read = 1'b1;
    @(negedge clk);
    check("t1_accept", 32'(m0_waitrequest), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1; m0_read = 1'b0;
    @(negedge clk);
    check("t1_no_rdv", 32'(m0_readdatavalid), 32'd0);
    check("t1_wait0", 32'(m0_waitrequest), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // m1 writes 0xA5 at the top address, m0 reads it back.
    drive_pair(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 15'h7FFF, 8'hA5);
    drive_pair(1'b1, 1'b0, 15'h7FFF, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t2_rdv", 32'(m0_readdatavalid), 32'd1);
    check("t2_data", 32'(m0_readdata), 32'hA5);
    @(posedge clk); #1;

    // Preload 0..7, then m0 streams reads with no bubbles.
    for (int i = 0; i < 8; i++)
      drive_pair(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, ADDR_W'(i), DATA_W'(8'h30 + i));
    base0 = n_rdv0;
    m0_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0_address = ADDR_W'(i);
      @(negedge clk);
      check("t3_accept", 32'(m0_waitrequest), 32'd0);
      @(posedge clk); #1;
    end
    m0_read = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    check("t3_valids", 32'(n_rdv0 - base0), 32'd8);

    // Continuous contention straight after reset.
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    apply_reset();
    m0_address = 15'h0040; m1_address = 15'h0041;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_one_winner", 32'(m0_waitrequest ^ m1_waitrequest), 32'd1);
      check("t4_pattern", 32'(m0_waitrequest), 32'(pat[i]));
      @(posedge clk); #1;
    end
    m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    // Simultaneous reads to distinct addresses return to their own ports.
    drive_pair(1'b1, 1'b1, 15'h0010, 8'h3C, 1'b1, 1'b1, 15'h0020, 8'hC3);
    base0 = n_rdv0; base1 = n_rdv1;
    drive_pair(1'b1, 1'b0, 15'h0010, '0, 1'b1, 1'b0, 15'h0020, '0);
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    check("t6_rdv0_count", 32'(n_rdv0 - base0), 32'd1);
    check("t6_rdv1_count", 32'(n_rdv1 - base1), 32'd1);

    // Randomized traffic from both masters.
    run_random(800);
    repeat (3) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
